ltc2387_decimator: RTL and testbench

- Consumes the two 18-bit sample streams from the LTC2387 deserializer (adc0/adc1 strobed by adc_valid) and decimates both channels by 2^log2_dec using a boxcar accumulate-and-dump.
- Delivers averaged samples through a valid/ready output port to the downstream DMA/FIFO.
- Both channels share one window counter, so their outputs are always time-aligned.

---
 rtl/ltc2387_decimator_if.sv | 22 ++
 rtl/ltc2387_decimator.sv | 154 +++++++++++++++
 tb/tb_ltc2387_decimator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2387_decimator_if.sv
// Sample stream from the LTC2387 deserializer and the decimated result stream to the DMA/FIFO.
interface ltc2387_decimator_if #(
   parameter int ADC_WIDTH = 18
);
   logic [ADC_WIDTH-1:0] adc0;
   logic [ADC_WIDTH-1:0] adc1;
   logic                 adc_valid;
   logic [ADC_WIDTH-1:0] dout0;
   logic [ADC_WIDTH-1:0] dout1;
   logic                 dout_valid;
   logic                 dout_ready;

   modport slave (
      input  adc0, adc1, adc_valid, dout_ready,
      output dout0, dout1, dout_valid
   );

   modport master (
      output adc0, adc1, adc_valid, dout_ready,
      input  dout0, dout1, dout_valid
   );
endinterface

// File: rtl/ltc2387_decimator.sv
// Two-channel boxcar accumulate-and-dump decimator by 2^log2_dec with valid/ready output.
// Optional DECIMATOR_ROUND_EN: round-half-up before the shift and saturate to the sample range.
module ltc2387_decimator #(
   parameter int ADC_WIDTH    = 18,
   parameter int MAX_LOG2_DEC = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic [3:0]         log2_dec,
   ltc2387_decimator_if.slave bus,
   output logic               overrun,
   input  logic               clear_overrun
);
   localparam int         ACC_W   = ADC_WIDTH + MAX_LOG2_DEC;
   localparam int         CW      = MAX_LOG2_DEC;
   localparam logic [3:0] MAX_DEC = 4'(MAX_LOG2_DEC);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
   state_t state, state_next;

   logic signed [ACC_W-1:0] acc0, acc1, ext0, ext1, sum0, sum1;
   logic [CW-1:0]           cnt, cnt_last;
   logic [CW:0]             one_shift;
   logic [3:0]              dec_l, dec_req, dec_eff;
   logic                    accept, first, last, transfer;
   logic [ADC_WIDTH-1:0]    res0, res1;

`ifdef DECIMATOR_ROUND_EN
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (ADC_WIDTH - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [ADC_WIDTH-1:0] round_sat(
      input logic signed [ACC_W-1:0] sum,
      input logic [3:0]              dec,
      input logic [CW:0]             pow
   );
      logic signed [ACC_W:0] biased;
      logic signed [ACC_W:0] shifted;
      // pow >> 1 is the half-LSB bias, and is zero for a pass-through window
      biased  = {sum[ACC_W-1], sum} + (ACC_W+1)'(pow >> 1);
      shifted = biased >>> dec;
      if (shifted > SAT_MAX) begin
         return ADC_WIDTH'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
         return ADC_WIDTH'(SAT_MIN);
      end else begin
         return ADC_WIDTH'(shifted);
      end
   endfunction
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (enable && bus.adc_valid) begin
               state_next = ACCUM;
            end else begin
               state_next = IDLE;
            end
         end
         ACCUM: begin
            if (!enable) begin
               state_next = IDLE;
            end else begin
               state_next = ACCUM;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Window bookkeeping and the candidate result for the current sample
   always_comb begin
      dec_req   = (log2_dec > MAX_DEC) ? MAX_DEC : log2_dec;
      accept    = enable & bus.adc_valid;
      first     = (state == IDLE) || (cnt == {CW{1'b0}});
      dec_eff   = first ? dec_req : dec_l;
      one_shift = {{CW{1'b0}}, 1'b1} << dec_eff;
      cnt_last  = CW'(one_shift - {{CW{1'b0}}, 1'b1});
      last      = accept && (cnt == cnt_last);
      transfer  = bus.dout_valid & bus.dout_ready;
      ext0      = {{MAX_LOG2_DEC{bus.adc0[ADC_WIDTH-1]}}, bus.adc0};
      ext1      = {{MAX_LOG2_DEC{bus.adc1[ADC_WIDTH-1]}}, bus.adc1};
      sum0      = acc0 + ext0;
      sum1      = acc1 + ext1;
`ifdef DECIMATOR_ROUND_EN
      res0      = round_sat(sum0, dec_eff, one_shift);
      res1      = round_sat(sum1, dec_eff, one_shift);
`else
      res0      = ADC_WIDTH'(sum0 >>> dec_eff);
      res1      = ADC_WIDTH'(sum1 >>> dec_eff);
`endif
   end

   // Accumulators, window counter and latched ratio
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc0  <= {ACC_W{1'b0}};
         acc1  <= {ACC_W{1'b0}};
         cnt   <= {CW{1'b0}};
         dec_l <= 4'd0;
      end else if (!enable) begin
         acc0 <= {ACC_W{1'b0}};
         acc1 <= {ACC_W{1'b0}};
         cnt  <= {CW{1'b0}};
      end else if (accept) begin
         dec_l <= dec_eff;
         if (last) begin
            acc0 <= {ACC_W{1'b0}};
            acc1 <= {ACC_W{1'b0}};
            cnt  <= {CW{1'b0}};
         end else begin
            acc0 <= sum0;
            acc1 <= sum1;
            cnt  <= cnt + CW'(1);
         end
      end
   end

   // Output register, handshake and sticky overrun (set beats clear)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.dout0      <= {ADC_WIDTH{1'b0}};
         bus.dout1      <= {ADC_WIDTH{1'b0}};
         bus.dout_valid <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (last && (!bus.dout_valid || bus.dout_ready)) begin
            bus.dout0      <= res0;
            bus.dout1      <= res1;
            bus.dout_valid <= 1'b1;
         end else if (transfer) begin
            bus.dout_valid <= 1'b0;
         end
         if (last && bus.dout_valid && !bus.dout_ready) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ltc2387_decimator.sv
// Self-checking bench for ltc2387_decimator against a window-level arithmetic reference model.
module tb_ltc2387_decimator;
   localparam int W = 18;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic [3:0] log2_dec;
   logic       overrun;
   logic       clear_overrun;
   int         n_tests = 0;
   int         n_fail  = 0;

   ltc2387_decimator_if #(.ADC_WIDTH(W)) bus ();

   ltc2387_decimator #(.ADC_WIDTH(W), .MAX_LOG2_DEC(8)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .log2_dec(log2_dec),
      .bus(bus), .overrun(overrun), .clear_overrun(clear_overrun)
   );

   always #5 clk = ~clk;

   // Reference model: one window = 2^dec samples, average = floor(sum / 2^dec)
   int     m_dec;
   int     m_cnt;
   longint m_sum0, m_sum1;
   bit     m_active;

   function automatic logic [W-1:0] model_avg(input longint sum, input int dec);
      longint v;
      v = sum;
`ifdef DECIMATOR_ROUND_EN
      if (dec > 0) v = v + (longint'(1) <<< (dec - 1));
`endif
      v = v >>> dec;
`ifdef DECIMATOR_ROUND_EN
      if (v > 131071) v = 131071;
      else if (v < -131072) v = -131072;
`endif
      return v[W-1:0];
   endfunction

   task automatic strobe(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                         output bit done, output logic [W-1:0] e0, output logic [W-1:0] e1);
      if (!m_active) begin
         m_dec    = (int'(log2_dec) > 8) ? 8 : int'(log2_dec);
         m_cnt    = 0;
         m_sum0   = 0;
         m_sum1   = 0;
         m_active = 1'b1;
      end
      m_sum0 += longint'(a0);
      m_sum1 += longint'(a1);
      m_cnt++;
      done = (m_cnt == (1 << m_dec));
      e0 = done ? model_avg(m_sum0, m_dec) : {W{1'b0}};
      e1 = done ? model_avg(m_sum1, m_dec) : {W{1'b0}};
      if (done) m_active = 1'b0;
      bus.adc0 = a0;
      bus.adc1 = a1;
      bus.adc_valid = 1'b1;
      @(negedge clk);
      bus.adc_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b0; log2_dec = 4'd0; clear_overrun = 1'b0;
      bus.adc0 = {W{1'b0}}; bus.adc1 = {W{1'b0}}; bus.adc_valid = 1'b0; bus.dout_ready = 1'b0;
      m_active = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.dout_valid !== 1'b0 || bus.dout0 !== {W{1'b0}} || bus.dout1 !== {W{1'b0}} || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: valid=%b dout0=%0d dout1=%0d overrun=%b, expected all 0",
                  bus.dout_valid, bus.dout0, bus.dout1, overrun);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int s[4] = '{10, 20, 30, 41};
      bit done; logic [W-1:0] e0, e1;
      log2_dec = 4'd2; enable = 1'b1; bus.dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         strobe(W'(s[i]), W'(-s[i]), done, e0, e1);
         n_tests++;
         if (bus.dout_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL basic_latency[%0d]: valid=%b expected %b", i, bus.dout_valid, (i == 3));
         end
      end
      n_tests++;
      if (bus.dout0 !== W'(25) || bus.dout1 !== e1) begin
         n_fail++;
         $display("FAIL basic_avg: dout0=%0d dout1=%0d expected 25 %0d",
                  $signed(bus.dout0), $signed(bus.dout1), $signed(e1));
      end
      @(negedge clk);
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drop: valid=%b expected 0 after transfer", bus.dout_valid);
      end
   endtask

   task automatic test_negative();
      bit done; logic [W-1:0] e0, e1;
      log2_dec = 4'd1;
      strobe(W'(-3), W'(131071), done, e0, e1);
      strobe(W'(-4), W'(131071), done, e0, e1);
      n_tests++;
      if (bus.dout_valid !== 1'b1 || bus.dout0 !== e0 || bus.dout1 !== W'(131071)) begin
         n_fail++;
         $display("FAIL negative: valid=%b dout0=%0d dout1=%0d expected 1 %0d 131071",
                  bus.dout_valid, $signed(bus.dout0), $signed(bus.dout1), $signed(e0));
      end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      bit done; logic [W-1:0] e0, e1, held;
      log2_dec = 4'd0; bus.dout_ready = 1'b0;
      strobe(W'(5), W'(55), done, e0, e1);
      held = e0;
      n_tests++;
      if (bus.dout_valid !== 1'b1 || bus.dout0 !== W'(5) || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_first: valid=%b dout0=%0d overrun=%b expected 1 5 0", bus.dout_valid, bus.dout0, overrun);
      end
      strobe(W'(6), W'(66), done, e0, e1);
      n_tests++;
      if (bus.dout0 !== held || bus.dout1 !== W'(55) || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_drop: dout0=%0d dout1=%0d overrun=%b expected 5 55 1", bus.dout0, bus.dout1, overrun);
      end
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      n_tests++;
      if (overrun !== 1'b0 || bus.dout_valid !== 1'b1 || bus.dout0 !== W'(5)) begin
         n_fail++;
         $display("FAIL ovr_clear: overrun=%b valid=%b dout0=%0d expected 0 1 5", overrun, bus.dout_valid, bus.dout0);
      end
      bus.dout_ready = 1'b1;
      strobe(W'(7), W'(77), done, e0, e1);
      n_tests++;
      if (bus.dout_valid !== 1'b1 || bus.dout0 !== W'(7) || bus.dout1 !== W'(77) || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_same_cycle: valid=%b dout0=%0d dout1=%0d overrun=%b expected 1 7 77 0",
                  bus.dout_valid, bus.dout0, bus.dout1, overrun);
      end
      bus.dout_ready = 1'b0; clear_overrun = 1'b1;
      strobe(W'(8), W'(88), done, e0, e1);
      clear_overrun = 1'b0;
      n_tests++;
      if (overrun !== 1'b1 || bus.dout0 !== W'(7)) begin
         n_fail++;
         $display("FAIL ovr_set_wins: overrun=%b dout0=%0d expected 1 7", overrun, bus.dout0);
      end
      bus.dout_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_release: valid=%b expected 0", bus.dout_valid);
      end
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
   endtask

   task automatic test_ratio_change();
      bit done; logic [W-1:0] e0, e1; bit exp_valid;
      log2_dec = 4'd3; bus.dout_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) log2_dec = 4'd1;
         strobe(W'($urandom), W'($urandom), done, e0, e1);
         exp_valid = (i == 7) || (i == 9) || (i == 11);
         n_tests++;
         if (bus.dout_valid !== exp_valid || (exp_valid && (bus.dout0 !== e0 || bus.dout1 !== e1))) begin
            n_fail++;
            $display("FAIL ratio_change[%0d]: valid=%b dout0=%0d dout1=%0d expected %b %0d %0d", i,
                     bus.dout_valid, $signed(bus.dout0), $signed(bus.dout1), exp_valid, $signed(e0), $signed(e1));
         end
      end
   endtask

   task automatic test_abort();
      bit done; logic [W-1:0] e0, e1;
      log2_dec = 4'd2;
      strobe(W'(100), W'(-100), done, e0, e1);
      strobe(W'(1000), W'(-1000), done, e0, e1);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      m_active = 1'b0;
      for (int i = 0; i < 4; i++) begin
         strobe(W'(8), W'(-8), done, e0, e1);
         n_tests++;
         if (bus.dout_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL abort_valid[%0d]: valid=%b expected %b", i, bus.dout_valid, (i == 3));
         end
      end
      n_tests++;
      if (bus.dout0 !== W'(8) || bus.dout1 !== W'(-8)) begin
         n_fail++;
         $display("FAIL abort_result: dout0=%0d dout1=%0d expected 8 -8", $signed(bus.dout0), $signed(bus.dout1));
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      bit done; logic [W-1:0] e0, e1;
      log2_dec = 4'd2; bus.dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) strobe(W'($urandom), W'($urandom), done, e0, e1);
      #2;
      resetn = 1'b0;
      #1;
      n_tests++;
      if (bus.dout_valid !== 1'b0 || bus.dout0 !== {W{1'b0}} || bus.dout1 !== {W{1'b0}} || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b dout0=%0d dout1=%0d overrun=%b expected all 0",
                  bus.dout_valid, bus.dout0, bus.dout1, overrun);
      end
      @(negedge clk);
      resetn = 1'b1;
      m_active = 1'b0;
      bus.dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) strobe(W'($urandom), W'($urandom), done, e0, e1);
      n_tests++;
      if (!done || bus.dout_valid !== 1'b1 || bus.dout0 !== e0 || bus.dout1 !== e1) begin
         n_fail++;
         $display("FAIL async_reset_window: valid=%b dout0=%0d dout1=%0d expected 1 %0d %0d",
                  bus.dout_valid, $signed(bus.dout0), $signed(bus.dout1), $signed(e0), $signed(e1));
      end
      @(negedge clk);
   endtask

   task automatic test_clamp();
      bit done; logic [W-1:0] e0, e1;
      log2_dec = 4'd15; bus.dout_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         strobe(W'($urandom), W'($urandom), done, e0, e1);
         n_tests++;
         if (bus.dout_valid !== (i == 255) || (i == 255 && (bus.dout0 !== e0 || bus.dout1 !== e1))) begin
            n_fail++;
            $display("FAIL clamp[%0d]: valid=%b dout0=%0d dout1=%0d expected %b %0d %0d", i, bus.dout_valid,
                     $signed(bus.dout0), $signed(bus.dout1), (i == 255), $signed(e0), $signed(e1));
         end
      end
   endtask

   task automatic test_random();
      bit done; logic [W-1:0] e0, e1;
      bus.dout_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         log2_dec = 4'($urandom_range(0, 5));
         strobe(W'($urandom), W'($urandom), done, e0, e1);
         n_tests++;
         if (bus.dout_valid !== done || (done && (bus.dout0 !== e0 || bus.dout1 !== e1))) begin
            n_fail++;
            $display("FAIL random[%0d]: valid=%b dout0=%0d dout1=%0d expected %b %0d %0d", i, bus.dout_valid,
                     $signed(bus.dout0), $signed(bus.dout1), done, $signed(e0), $signed(e1));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL random_overrun: overrun=%b expected 0", overrun);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_overrun();
      test_ratio_change();
      test_abort();
      test_async_reset();
      test_clamp();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
